dmem_store_buffer: RTL and testbench

Posted-write buffer between the memory-stage address/byte-enable logic and the data-memory write port. Accepts aligned store requests (word address, replicated data, byte write-enables) in one cycle and retires them to dmem in FIFO order whenever the dmem port is not claimed by a load. Raises a stall for any load whose word address matches a pending store, so load data reaching the load-extension logic is never stale.

---
 rtl/dmem_store_buffer.sv | 108 ++++++++++
 tb/tb_dmem_store_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer.sv
// Posted-write FIFO between the memory stage and the dmem write port; stalls loads that hit pending stores.
// Optional store-to-load forwarding of full-word entries is enabled by defining STBUF_FWD_EN.
module dmem_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      st_valid,
    output logic                      st_ready,
    input  logic [ADDR_W-1:0]         st_addr,
    input  logic [31:0]               st_data,
    input  logic [3:0]                st_we,
    input  logic                      ld_valid,
    input  logic [ADDR_W-1:0]         ld_addr,
    output logic                      ld_stall,
    input  logic                      mem_busy,
    output logic [3:0]                mem_we,
    output logic [ADDR_W-1:0]         mem_adr,
    output logic [31:0]               mem_din,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
`ifdef STBUF_FWD_EN
    ,
    output logic                      fwd_hit,
    output logic [31:0]               fwd_data
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [31:0]       ent_data [DEPTH];
    logic [3:0]        ent_we   [DEPTH];
    logic [DEPTH-1:0]  ent_valid;
    logic [PTR_W-1:0]  head, tail, idx;
    logic [CNT_W-1:0]  cnt;
    logic              enq, drain, match_any;
    logic              young_full;
    logic [31:0]       young_data;

    // st_ready looks only at the registered count so a same-cycle drain never opens a slot.
    assign st_ready = (cnt != FULL);
    assign enq      = st_valid & st_ready & (st_we != 4'b0000);
    assign drain    = (cnt != '0) & ~mem_busy;
    assign mem_adr  = ent_addr[head];
    assign mem_din  = ent_data[head];
    assign mem_we   = drain ? ent_we[head] : 4'b0000;
    assign empty    = (cnt == '0);
    assign count    = cnt;

    // Walk oldest to youngest so the last hit left standing is the youngest match.
    always_comb begin
        match_any  = 1'b0;
        young_full = 1'b0;
        young_data = '0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (ent_valid[idx] && (ent_addr[idx] == ld_addr)) begin
                match_any  = 1'b1;
                young_full = (ent_we[idx] == 4'b1111);
                young_data = ent_data[idx];
            end
        end
    end

`ifdef STBUF_FWD_EN
    assign ld_stall = ld_valid & (st_valid | (match_any & ~young_full));
    assign fwd_hit  = ld_valid & ~st_valid & match_any & young_full;
    assign fwd_data = fwd_hit ? young_data : 32'h0;
`else
    assign ld_stall = ld_valid & (st_valid | match_any);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            cnt       <= '0;
            ent_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
                ent_we[i]   <= '0;
            end
        end else begin
            if (enq) begin
                ent_addr[tail]  <= st_addr;
                ent_data[tail]  <= st_data;
                ent_we[tail]    <= st_we;
                ent_valid[tail] <= 1'b1;
                tail            <= tail + PTR_W'(1);
            end
            // Head and tail only coincide when empty or full, so these never hit the same slot.
            if (drain) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PTR_W'(1);
            end
            case ({enq, drain})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer: per-cycle vector table plus hand sequences for reset
// mid-drain and (when STBUF_FWD_EN is defined) forwarding.
module tb_dmem_store_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [11:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [3:0]  st_we = '0;
    logic        ld_valid = 1'b0;
    logic [11:0] ld_addr = '0;
    logic        ld_stall;
    logic        mem_busy = 1'b0;
    logic [3:0]  mem_we;
    logic [11:0] mem_adr;
    logic [31:0] mem_din;
    logic        empty;
    logic [2:0]  count;
`ifdef STBUF_FWD_EN
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    int n_chk = 0;
    int n_fail = 0;

    dmem_store_buffer #(.DEPTH(4), .ADDR_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_we(st_we),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
        .mem_busy(mem_busy), .mem_we(mem_we), .mem_adr(mem_adr), .mem_din(mem_din),
        .empty(empty), .count(count)
`ifdef STBUF_FWD_EN
        , .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n, sv;
        logic [11:0] sa;
        logic [31:0] sd;
        logic [3:0]  swe;
        logic        lv;
        logic [11:0] la;
        logic        busy;
        logic        rdy, stall;
        logic [3:0]  mwe;
        logic [11:0] madr;
        logic [31:0] mdin;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(logic r, logic sv, logic [11:0] sa, logic [31:0] sd, logic [3:0] swe,
                              logic lv, logic [11:0] la, logic busy, logic rdy, logic stall,
                              logic [3:0] mwe, logic [11:0] madr, logic [31:0] mdin, logic [2:0] cnt);
        vec_t e;
        e.rst_n = r; e.sv = sv; e.sa = sa; e.sd = sd; e.swe = swe; e.lv = lv; e.la = la;
        e.busy = busy; e.rdy = rdy; e.stall = stall; e.mwe = mwe; e.madr = madr;
        e.mdin = mdin; e.cnt = cnt;
        vecs.push_back(e);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        st_valid = 1'b0; st_we = 4'b0; ld_valid = 1'b0; mem_busy = 1'b0;
    endtask

    initial begin
        // rst sv  sa      sd            swe    lv la      busy rdy stl mwe    madr    mdin          cnt
        v(0, 0, 12'h000, 32'h0,        4'h0, 0, 12'h000, 0, 1, 0, 4'h0, 12'h000, 32'h0,        3'd0);
        v(1, 1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 12'h000, 0, 1, 0, 4'h0, 12'h000, 32'h0,        3'd0);
        v(1, 0, 12'h000, 32'h0,        4'h0, 0, 12'h000, 0, 1, 0, 4'hF, 12'h010, 32'hDEADBEEF, 3'd1);
        v(1, 0, 12'h000, 32'h0,        4'h0, 0, 12'h000, 0, 1, 0, 4'h0, 12'h000, 32'h0,        3'd0);
        // fill while dmem is busy, then drain with wrap-around refills
        v(1, 1, 12'h100, 32'h11111111, 4'hF, 0, 12'h000, 1, 1, 0, 4'h0, 12'h000, 32'h0,        3'd0);
        v(1, 1, 12'h101, 32'h22222222, 4'hF, 0, 12'h000, 1, 1, 0, 4'h0, 12'h000, 32'h0,        3'd1);
        v(1, 1, 12'h102, 32'h33333333, 4'hF, 0, 12'h000, 1, 1, 0, 4'h0, 12'h000, 32'h0,        3'd2);
        v(1, 1, 12'h103, 32'h44444444, 4'hF, 0, 12'h000, 1, 1, 0, 4'h0, 12'h000, 32'h0,        3'd3);
        v(1, 1, 12'h104, 32'h55555555, 4'hF, 0, 12'h000, 1, 0, 0, 4'h0, 12'h000, 32'h0,        3'd4);
        v(1, 1, 12'h104, 32'h55555555, 4'hF, 0, 12'h000, 0, 0, 0, 4'hF, 12'h100, 32'h11111111, 3'd4);
        v(1, 1, 12'h104, 32'h55555555, 4'hF, 0, 12'h000, 0, 1, 0, 4'hF, 12'h101, 32'h22222222, 3'd3);
        v(1, 1, 12'h105, 32'h66666666, 4'hF, 0, 12'h000, 0, 1, 0, 4'hF, 12'h102, 32'h33333333, 3'd3);
        v(1, 1, 12'h106, 32'h77777777, 4'hF, 0, 12'h000, 0, 1, 0, 4'hF, 12'h103, 32'h44444444, 3'd3);
        v(1, 0, 12'h000, 32'h0,        4'h0, 0, 12'h000, 0, 1, 0, 4'hF, 12'h104, 32'h55555555, 3'd3);
        v(1, 0, 12'h000, 32'h0,        4'h0, 0, 12'h000, 0, 1, 0, 4'hF, 12'h105, 32'h66666666, 3'd2);
        v(1, 0, 12'h000, 32'h0,        4'h0, 0, 12'h000, 0, 1, 0, 4'hF, 12'h106, 32'h77777777, 3'd1);
        v(1, 0, 12'h000, 32'h0,        4'h0, 0, 12'h000, 0, 1, 0, 4'h0, 12'h000, 32'h0,        3'd0);
        // load hazard on a pending byte store
        v(1, 1, 12'h01F, 32'hAAAA0000, 4'hC, 0, 12'h000, 1, 1, 0, 4'h0, 12'h000, 32'h0,        3'd0);
        v(1, 1, 12'h020, 32'h0000AB00, 4'h2, 0, 12'h000, 1, 1, 0, 4'h0, 12'h000, 32'h0,        3'd1);
        v(1, 0, 12'h000, 32'h0,        4'h0, 1, 12'h024, 1, 1, 0, 4'h0, 12'h000, 32'h0,        3'd2);
        v(1, 0, 12'h000, 32'h0,        4'h0, 1, 12'h020, 0, 1, 1, 4'hC, 12'h01F, 32'hAAAA0000, 3'd2);
        v(1, 0, 12'h000, 32'h0,        4'h0, 1, 12'h020, 0, 1, 1, 4'h2, 12'h020, 32'h0000AB00, 3'd1);
        v(1, 0, 12'h000, 32'h0,        4'h0, 1, 12'h020, 0, 1, 0, 4'h0, 12'h000, 32'h0,        3'd0);
        // concurrent store and load: store wins
        v(1, 1, 12'h040, 32'hCAFEF00D, 4'hF, 1, 12'h050, 0, 1, 1, 4'h0, 12'h000, 32'h0,        3'd0);
        v(1, 0, 12'h000, 32'h0,        4'h0, 1, 12'h050, 0, 1, 0, 4'hF, 12'h040, 32'hCAFEF00D, 3'd1);
        // enqueue+drain at count 2, then a st_we==0 store that must never reach dmem
        v(1, 1, 12'h060, 32'h01010101, 4'hF, 0, 12'h000, 1, 1, 0, 4'h0, 12'h000, 32'h0,        3'd0);
        v(1, 1, 12'h061, 32'h02020202, 4'hF, 0, 12'h000, 1, 1, 0, 4'h0, 12'h000, 32'h0,        3'd1);
        v(1, 1, 12'h062, 32'h03030303, 4'hF, 0, 12'h000, 0, 1, 0, 4'hF, 12'h060, 32'h01010101, 3'd2);
        v(1, 1, 12'h063, 32'h04040404, 4'h0, 0, 12'h000, 1, 1, 0, 4'h0, 12'h000, 32'h0,        3'd2);
        v(1, 0, 12'h000, 32'h0,        4'h0, 0, 12'h000, 0, 1, 0, 4'hF, 12'h061, 32'h02020202, 3'd2);
        v(1, 0, 12'h000, 32'h0,        4'h0, 0, 12'h000, 0, 1, 0, 4'hF, 12'h062, 32'h03030303, 3'd1);
        v(1, 0, 12'h000, 32'h0,        4'h0, 0, 12'h000, 0, 1, 0, 4'h0, 12'h000, 32'h0,        3'd0);

        foreach (vecs[k]) begin
            @(negedge clk);
            rst_n = vecs[k].rst_n; st_valid = vecs[k].sv; st_addr = vecs[k].sa;
            st_data = vecs[k].sd; st_we = vecs[k].swe; ld_valid = vecs[k].lv;
            ld_addr = vecs[k].la; mem_busy = vecs[k].busy;
            #1;
            chk("st_ready", k, 32'(st_ready), 32'(vecs[k].rdy));
            chk("ld_stall", k, 32'(ld_stall), 32'(vecs[k].stall));
            chk("mem_we",   k, 32'(mem_we),   32'(vecs[k].mwe));
            chk("count",    k, 32'(count),    32'(vecs[k].cnt));
            chk("empty",    k, 32'(empty),    32'(vecs[k].cnt == 3'd0));
            if (vecs[k].mwe != 4'h0) begin
                chk("mem_adr", k, 32'(mem_adr), 32'(vecs[k].madr));
                chk("mem_din", k, mem_din, vecs[k].mdin);
            end
        end

        // reset asserted mid-drain with three entries pending
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            st_valid = 1'b1; st_addr = 12'h070 + 12'(i); st_data = 32'hA0A0A0A0 + i;
            st_we = 4'hF; mem_busy = 1'b1; ld_valid = 1'b0;
        end
        @(negedge clk);
        idle_inputs();
        ld_valid = 1'b1; ld_addr = 12'h071;
        #1;
        chk("rst_pre_mem_we", 100, 32'(mem_we), 32'hF);
        chk("rst_pre_count",  100, 32'(count),  32'd3);
        chk("rst_pre_stall",  100, 32'(ld_stall), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mem_we",   101, 32'(mem_we),   32'h0);
        chk("rst_count",    101, 32'(count),    32'd0);
        chk("rst_empty",    101, 32'(empty),    32'd1);
        chk("rst_st_ready", 101, 32'(st_ready), 32'd1);
        chk("rst_ld_stall", 101, 32'(ld_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; ld_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("post_rst_mem_we", 102 + i, 32'(mem_we), 32'h0);
            chk("post_rst_count",  102 + i, 32'(count),  32'd0);
            @(negedge clk);
        end

`ifdef STBUF_FWD_EN
        // SH then SW to the same word: youngest is full-width, so forward
        st_valid = 1'b1; st_addr = 12'h030; st_data = 32'hABCDABCD; st_we = 4'hC; mem_busy = 1'b1;
        @(negedge clk);
        st_data = 32'h12345678; st_we = 4'hF;
        @(negedge clk);
        st_valid = 1'b0; st_we = 4'h0; ld_valid = 1'b1; ld_addr = 12'h030;
        #1;
        chk("fwd_hit",   200, 32'(fwd_hit),  32'd1);
        chk("fwd_data",  200, fwd_data,      32'h12345678);
        chk("fwd_stall", 200, 32'(ld_stall), 32'd0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        // SW then SH: youngest is partial, so stall until both have drained
        st_valid = 1'b1; st_data = 32'h12345678; st_we = 4'hF; mem_busy = 1'b1;
        @(negedge clk);
        st_data = 32'hABCDABCD; st_we = 4'hC;
        @(negedge clk);
        st_valid = 1'b0; st_we = 4'h0; mem_busy = 1'b0; ld_valid = 1'b1;
        #1;
        chk("part_stall", 201, 32'(ld_stall), 32'd1);
        chk("part_hit",   201, 32'(fwd_hit),  32'd0);
        @(negedge clk);
        #1;
        chk("part_stall2", 202, 32'(ld_stall), 32'd1);
        @(negedge clk);
        #1;
        chk("part_release", 203, 32'(ld_stall), 32'd0);
        chk("part_nohit",   203, 32'(fwd_hit),  32'd0);
        idle_inputs();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
